move_objects: RTL and testbench

- Parametrised successor to the single-ship mover. Holds position and velocity for NUM_OBJ independent screen objects (asteroids, bullets, debris) in one block.
- Advances every active object by its velocity once per update tick, with toroidal screen wrap-around.
- One shared adder/wrap datapath is time-multiplexed over the slots.
- Objects are created through a valid/ready spawn port and removed through a kill port. A registered read port feeds the drawing logic.

---
 rtl/move_objects.sv | 184 ++++++++++++++++++
 tb/tb_move_objects.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_objects.sv
// move_objects: position/velocity store for NUM_OBJ screen objects.
// A single shared adder/wrap datapath is time-multiplexed over all slots once
// per update tick. Objects are created through a valid/ready spawn port and
// removed through a kill port. A registered read port serves the drawing logic.
module move_objects #(
    parameter  int WIDTH       = 640,
    parameter  int HEIGHT      = 480,
    parameter  int NUM_OBJ     = 8,
    parameter  int XY_FRACTION = 16,
    parameter  int SPEED_W     = 20,
    parameter  int DIVIDER     = 125_000,
    localparam int X_W         = $clog2(WIDTH),
    localparam int Y_W         = $clog2(HEIGHT),
    localparam int IDX_W       = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      spawn_valid,
    output logic                      spawn_ready,
    input  logic [X_W-1:0]            spawn_x,
    input  logic [Y_W-1:0]            spawn_y,
    input  logic signed [SPEED_W-1:0] spawn_vx,
    input  logic signed [SPEED_W-1:0] spawn_vy,
    output logic [IDX_W-1:0]          spawn_idx,
    input  logic                      kill_valid,
    input  logic [IDX_W-1:0]          kill_idx,
    input  logic [IDX_W-1:0]          rd_idx,
    output logic [X_W-1:0]            rd_x,
    output logic [Y_W-1:0]            rd_y,
    output logic                      rd_active,
    output logic [NUM_OBJ-1:0]        active_mask,
    output logic                      frame_done
);

    localparam int XP_W  = X_W + XY_FRACTION;
    localparam int YP_W  = Y_W + XY_FRACTION;
    localparam int XT_W  = XP_W + 2;
    localparam int YT_W  = YP_W + 2;
    localparam int CNT_W = $clog2(DIVIDER);

    // Span constants live in position width: when the screen size is a power
    // of two the span truncates to zero and the modular add wraps by itself.
    localparam logic [XP_W-1:0] X_SPAN = XP_W'(WIDTH) << XY_FRACTION;
    localparam logic [YP_W-1:0] Y_SPAN = YP_W'(HEIGHT) << XY_FRACTION;
    localparam logic [X_W:0]    X_LIM  = (X_W + 1)'(WIDTH);
    localparam logic [Y_W:0]    Y_LIM  = (Y_W + 1)'(HEIGHT);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          slot;
    logic [CNT_W-1:0]          tick_cnt;
    logic                      tick;
    logic [NUM_OBJ-1:0]        active;
    logic [XP_W-1:0]           pos_x [NUM_OBJ];
    logic [YP_W-1:0]           pos_y [NUM_OBJ];
    logic signed [SPEED_W-1:0] vel_x [NUM_OBJ];
    logic signed [SPEED_W-1:0] vel_y [NUM_OBJ];

    logic [XT_W-1:0]           sum_x;
    logic [YT_W-1:0]           sum_y;
    logic [XP_W-1:0]           next_x;
    logic [YP_W-1:0]           next_y;

    assign tick        = (tick_cnt == CNT_W'(DIVIDER - 1));
    assign spawn_ready = ~&active;
    assign active_mask = active;

    // Free-running update-tick divider.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Shared datapath: advance the swept slot by its velocity and wrap once.
    always_comb begin
        sum_x = {2'b00, pos_x[slot]}
              + {{(XT_W - SPEED_W){vel_x[slot][SPEED_W-1]}}, vel_x[slot]};
        sum_y = {2'b00, pos_y[slot]}
              + {{(YT_W - SPEED_W){vel_y[slot][SPEED_W-1]}}, vel_y[slot]};
        if (sum_x[XT_W-1]) begin
            next_x = sum_x[XP_W-1:0] + X_SPAN;
        end else if (sum_x[XT_W-2:XY_FRACTION] >= X_LIM) begin
            next_x = sum_x[XP_W-1:0] - X_SPAN;
        end else begin
            next_x = sum_x[XP_W-1:0];
        end
        if (sum_y[YT_W-1]) begin
            next_y = sum_y[YP_W-1:0] + Y_SPAN;
        end else if (sum_y[YT_W-2:XY_FRACTION] >= Y_LIM) begin
            next_y = sum_y[YP_W-1:0] - Y_SPAN;
        end else begin
            next_y = sum_y[YP_W-1:0];
        end
    end

    // Lowest free slot, taken from the registered (pre-kill) mask.
    always_comb begin
        spawn_idx = '0;
        for (int unsigned i = NUM_OBJ; i > 0; i--) begin
            if (!active[i-1]) begin
                spawn_idx = IDX_W'(i - 1);
            end
        end
    end

    // Sweep FSM plus slot store; kill is applied before spawn so a spawn into
    // an already-inactive slot named by kill_idx still takes effect.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            slot       <= '0;
            frame_done <= 1'b0;
            active     <= '0;
            for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
                vel_x[i] <= '0;
                vel_y[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= SWEEP;
                        slot  <= '0;
                    end
                end
                SWEEP: begin
                    if (active[slot]) begin
                        pos_x[slot] <= next_x;
                        pos_y[slot] <= next_y;
                    end
                    if (slot == IDX_W'(NUM_OBJ - 1)) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end else begin
                        slot <= slot + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (kill_valid) begin
                active[kill_idx] <= 1'b0;
            end
            if (spawn_valid && spawn_ready) begin
                active[spawn_idx] <= 1'b1;
                pos_x[spawn_idx]  <= {spawn_x, {XY_FRACTION{1'b0}}};
                pos_y[spawn_idx]  <= {spawn_y, {XY_FRACTION{1'b0}}};
                vel_x[spawn_idx]  <= spawn_vx;
                vel_y[spawn_idx]  <= spawn_vy;
            end
        end
    end

    // Registered read port for the drawing logic.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_x      <= '0;
            rd_y      <= '0;
            rd_active <= 1'b0;
        end else begin
            rd_x      <= pos_x[rd_idx][XP_W-1:XY_FRACTION];
            rd_y      <= pos_y[rd_idx][YP_W-1:XY_FRACTION];
            rd_active <= active[rd_idx];
        end
    end

endmodule

// File: tb/tb_move_objects.sv
// Bench for move_objects: a driver runs a slot-level reference model and
// queues the expected post-edge outputs; a monitor pops and compares them.
module tb_move_objects;

    localparam int W     = 640;
    localparam int H     = 480;
    localparam int N     = 4;
    localparam int XF    = 16;
    localparam int SW    = 20;
    localparam int DIV   = 16;
    localparam int XW    = 10;
    localparam int YW    = 9;
    localparam int IW    = 2;
    localparam int XSPAN = W << XF;
    localparam int YSPAN = H << XF;

    logic                 clk;
    logic                 resetN;
    logic                 spawn_valid;
    logic                 spawn_ready;
    logic [XW-1:0]        spawn_x;
    logic [YW-1:0]        spawn_y;
    logic [SW-1:0]        spawn_vx;
    logic [SW-1:0]        spawn_vy;
    logic [IW-1:0]        spawn_idx;
    logic                 kill_valid;
    logic [IW-1:0]        kill_idx;
    logic [IW-1:0]        rd_idx;
    logic [XW-1:0]        rd_x;
    logic [YW-1:0]        rd_y;
    logic                 rd_active;
    logic [N-1:0]         active_mask;
    logic                 frame_done;

    move_objects #(
        .WIDTH(W),
        .HEIGHT(H),
        .NUM_OBJ(N),
        .XY_FRACTION(XF),
        .SPEED_W(SW),
        .DIVIDER(DIV)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .spawn_valid(spawn_valid),
        .spawn_ready(spawn_ready),
        .spawn_x(spawn_x),
        .spawn_y(spawn_y),
        .spawn_vx(spawn_vx),
        .spawn_vy(spawn_vy),
        .spawn_idx(spawn_idx),
        .kill_valid(kill_valid),
        .kill_idx(kill_idx),
        .rd_idx(rd_idx),
        .rd_x(rd_x),
        .rd_y(rd_y),
        .rd_active(rd_active),
        .active_mask(active_mask),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       rd_x;
        int       rd_y;
        bit       rd_active;
        bit [N-1:0] mask;
        bit       ready;
        int       idx;
        bit       fdone;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: subpixel positions as plain integers.
    int       mx [N];
    int       my [N];
    int       mvx[N];
    int       mvy[N];
    bit [N-1:0] mact;
    int       ecount;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int wrap(input int v, input int span);
        return ((v % span) + span) % span;
    endfunction

    function automatic int lowest_free(input bit [N-1:0] m);
        int r;
        r = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (!m[i]) r = i;
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0;
        end
        mact   = '0;
        ecount = 0;
    endtask

    // Drive one cycle of stimulus at a negedge, predict the post-edge outputs,
    // queue them, then wait for the next negedge.
    task automatic step(input bit sv, input int sx, input int sy,
                        input logic [SW-1:0] svx, input logic [SW-1:0] svy,
                        input bit kv, input int ki, input int ri);
        exp_t     e;
        int       n;
        int       s;
        int       free;
        bit [N-1:0] pre;
        spawn_valid = sv;
        spawn_x     = XW'(sx);
        spawn_y     = YW'(sy);
        spawn_vx    = svx;
        spawn_vy    = svy;
        kill_valid  = kv;
        kill_idx    = IW'(ki);
        rd_idx      = IW'(ri);
        n   = ecount + 1;
        pre = mact;
        e.rd_active = pre[ri];
        e.rd_x      = mx[ri] >> XF;
        e.rd_y      = my[ri] >> XF;
        // Slot s of each frame is advanced DIV+1+s edges into the period.
        if (n >= DIV + 1 && ((n - DIV - 1) % DIV) < N) begin
            s = (n - DIV - 1) % DIV;
            if (pre[s]) begin
                mx[s] = wrap(mx[s] + mvx[s], XSPAN);
                my[s] = wrap(my[s] + mvy[s], YSPAN);
            end
        end
        e.fdone = (n >= DIV + N) && (((n - DIV - N) % DIV) == 0);
        free = lowest_free(pre);
        if (kv) mact[ki] = 1'b0;
        if (sv && free >= 0) begin
            mact[free] = 1'b1;
            mx[free]   = sx << XF;
            my[free]   = sy << XF;
            mvx[free]  = int'($signed(svx));
            mvy[free]  = int'($signed(svy));
        end
        e.mask  = mact;
        e.ready = (mact != '1);
        e.idx   = lowest_free(mact);
        q.push_back(e);
        ecount++;
        @(negedge clk);
    endtask

    task automatic idle(input int ri);
        step(1'b0, 0, 0, '0, '0, 1'b0, 0, ri);
    endtask

    task automatic rand_step();
        step($urandom_range(0, 3) == 0, $urandom_range(0, W - 1), $urandom_range(0, H - 1),
             SW'($urandom), SW'($urandom), $urandom_range(0, 5) == 0,
             $urandom_range(0, N - 1), $urandom_range(0, N - 1));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rd_x"}, rd_x, 0);
        chk({tag, "_rd_y"}, rd_y, 0);
        chk({tag, "_rd_active"}, rd_active, 0);
        chk({tag, "_mask"}, active_mask, 0);
        chk({tag, "_ready"}, spawn_ready, 1);
        chk({tag, "_spawn_idx"}, spawn_idx, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    // Monitor: every cycle with a queued prediction, compare the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_active", rd_active, e.rd_active);
                if (e.rd_active) begin
                    chk("rd_x", rd_x, e.rd_x);
                    chk("rd_y", rd_y, e.rd_y);
                end
                chk("active_mask", active_mask, e.mask);
                chk("spawn_ready", spawn_ready, e.ready);
                if (e.ready) chk("spawn_idx", spawn_idx, e.idx);
                chk("frame_done", frame_done, e.fdone);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        resetN      = 1'b0;
        spawn_valid = 1'b0;
        spawn_x     = '0;
        spawn_y     = '0;
        spawn_vx    = '0;
        spawn_vy    = '0;
        kill_valid  = 1'b0;
        kill_idx    = '0;
        rd_idx      = '0;
        model_clear();
        repeat (2) @(negedge clk);
        reset_checks("por");
        resetN = 1'b1;

        // Directed motion and wrap cases.
        step(1'b1, 100, 50, 20'h18000, 20'hF0000, 1'b0, 0, 0);
        step(1'b1, 639, 479, 20'h10000, 20'h10000, 1'b0, 0, 0);
        step(1'b1, 0, 0, 20'hF8000, 20'hF8000, 1'b0, 0, 0);
        while (ecount < 20) idle(0);
        idle(0); chk("t1_s0_x", rd_x, 101); chk("t1_s0_y", rd_y, 49);
        idle(1); chk("t1_s1_x", rd_x, 0);   chk("t1_s1_y", rd_y, 0);
        idle(2); chk("t1_s2_x", rd_x, 639); chk("t1_s2_y", rd_y, 479);
        while (ecount < 36) idle(0);
        idle(0); chk("t2_s0_x", rd_x, 103); chk("t2_s0_y", rd_y, 48);
        idle(1); chk("t2_s1_x", rd_x, 1);   chk("t2_s1_y", rd_y, 1);
        idle(2); chk("t2_s2_x", rd_x, 639); chk("t2_s2_y", rd_y, 479);

        // Fill all slots, then a spawn with no free slot.
        step(1'b1, 320, 240, 20'h00000, 20'h00000, 1'b0, 0, 3);
        chk("full_mask", active_mask, 4'b1111);
        chk("full_ready", spawn_ready, 0);
        step(1'b1, 5, 5, 20'h12345, 20'h54321, 1'b0, 0, 3);
        chk("ignored_mask", active_mask, 4'b1111);
        idle(3); chk("ignored_s3_x", rd_x, 320); chk("ignored_s3_y", rd_y, 240);

        // Kill and spawn together on a full mask.
        step(1'b1, 10, 20, 20'h00000, 20'h00000, 1'b1, 2, 2);
        chk("kill_mask", active_mask, 4'b1011);
        chk("kill_ready", spawn_ready, 1);
        chk("kill_spawn_idx", spawn_idx, 2);
        step(1'b1, 10, 20, 20'h00000, 20'h00000, 1'b0, 0, 2);
        chk("respawn_mask", active_mask, 4'b1111);
        idle(2); chk("respawn_x", rd_x, 10); chk("respawn_y", rd_y, 20);

        repeat (700) rand_step();

        // Reset while the sweep is about to process slot 2.
        while (!((ecount + 1) >= DIV + 1 && ((ecount + 1 - DIV - 1) % DIV) == 2)) begin
            idle($urandom_range(0, N - 1));
        end
        resetN = 1'b0;
        #1;
        reset_checks("midsweep");
        model_clear();
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        repeat (40) idle($urandom_range(0, N - 1));
        repeat (200) rand_step();

        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
